fxp_multiplier: RTL and testbench

FXP_MULTIPLIER -- requirements
Module: fxp_multiplier

---
 rtl/fxp_multiplier.sv | 234 +++++++++++++++++++++++
 tb/tb_fxp_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_multiplier.sv
// fxp_multiplier: pipelined signed fixed-point multiplier, Lanes parallel lanes
// sharing one valid/ready handshake. Each lane forms the full 2*Width product,
// rounds half-up, then slices out OutPoint fractional bits.
//
// Build option: define FXP_MULTIPLIER_SAT_EN to clamp overflowing lanes to the
// signed Width-bit extremes and report them on overflow_o. Without it results
// wrap (plain bit slice) and overflow_o stays 0.
//
// Pipeline: with Latency >= 2 stage 1 holds raw products and stage 2 holds the
// rounded results; further stages only delay. With Latency == 1 the whole
// datapath sits in front of the single result stage.
module fxp_multiplier #(
    parameter int Width    = 16,
    parameter int InPoint  = 10,
    parameter int OutPoint = 10,
    parameter int Lanes    = 1,
    parameter int Latency  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [Lanes*Width-1:0] a_i,
    input  logic [Lanes*Width-1:0] b_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [Lanes*Width-1:0] m_o,
    output logic [Lanes-1:0]       overflow_o
);

    localparam int Shift    = 2 * InPoint - OutPoint;
    localparam int PW       = 2 * Width;
    localparam int RW       = Lanes * Width;
    localparam int FirstIdx = (Latency == 1) ? 0 : 1;
    localparam int RndPos   = (Shift > 0) ? (Shift - 1) : 0;
    localparam logic [PW-1:0] RndConst =
        (Shift > 0) ? ({{(PW-1){1'b0}}, 1'b1} << RndPos) : {PW{1'b0}};

    // Reject configurations the datapath cannot represent.
    generate
        if (Shift < 0 || Shift > Width) begin : g_bad_shift
            $error("fxp_multiplier: 2*InPoint-OutPoint must lie in 0..Width");
        end
        if (Latency < 1 || Latency > 4) begin : g_bad_latency
            $error("fxp_multiplier: Latency must lie in 1..4");
        end
    endgenerate

    // Full-precision signed product of one lane (two's complement, 2*Width bits).
    function automatic logic [PW-1:0] lane_product(input logic [Width-1:0] a,
                                                   input logic [Width-1:0] b);
        logic [PW-1:0] a_ext;
        logic [PW-1:0] b_ext;
        a_ext = {{Width{a[Width-1]}}, a};
        b_ext = {{Width{b[Width-1]}}, b};
        return a_ext * b_ext;
    endfunction

    // Round half-up, slice the result window and resolve overflow for one lane.
    // Returns {overflow, result}.
    function automatic logic [Width:0] lane_round(input logic [PW-1:0] prod);
        logic [PW-1:0]    rounded;
        logic [PW-1:0]    scaled;
        logic [Width-1:0] slice;
`ifdef FXP_MULTIPLIER_SAT_EN
        logic             ovf;
`endif
        rounded = prod + RndConst;
        scaled  = $signed(rounded) >>> Shift;
        slice   = scaled[Width-1:0];
`ifdef FXP_MULTIPLIER_SAT_EN
        // Every bit above the window must repeat the window's sign bit.
        ovf = (scaled != {{Width{slice[Width-1]}}, slice});
        if (ovf) begin
            if (rounded[PW-1]) begin
                slice = {1'b1, {(Width-1){1'b0}}};
            end else begin
                slice = {1'b0, {(Width-1){1'b1}}};
            end
        end else begin
            slice = scaled[Width-1:0];
        end
        return {ovf, slice};
`else
        return {1'b0, slice};
`endif
    endfunction

    // ------------------------------------------------------------------
    // Handshake / occupancy
    // ------------------------------------------------------------------
    logic [Latency-1:0] valid_q;
    logic [Latency-1:0] valid_d;
    logic [Latency-1:0] load_s;
    logic [Latency-1:0] feed_s;
    logic [Latency-1:0] cap_s;

    // A stage may load when it or any stage downstream is empty, or the output drains.
    always_comb begin
        load_s = {Latency{1'b0}};
        for (int k = 0; k < Latency; k++) begin
            logic room_v;
            room_v = m_ready_i;
            for (int j = k; j < Latency; j++) begin
                room_v = room_v | ~valid_q[j];
            end
            load_s[k] = room_v;
        end
    end

    // Next occupancy: a loading stage takes its upstream valid, others hold.
    always_comb begin
        feed_s    = {Latency{1'b0}};
        feed_s[0] = s_valid_i;
        for (int k = 1; k < Latency; k++) begin
            feed_s[k] = valid_q[k-1];
        end
        cap_s   = load_s & feed_s;
        valid_d = (load_s & feed_s) | (~load_s & valid_q);
    end

    // Stage occupancy flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= {Latency{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [Lanes*PW-1:0] prod_in_s;
    logic [Lanes*PW-1:0] post_src_s;
    logic [RW-1:0]       post_res_s;
    logic [Lanes-1:0]    post_ovf_s;

    // Full-precision per-lane products of the incoming operands.
    always_comb begin
        prod_in_s = {(Lanes*PW){1'b0}};
        for (int n = 0; n < Lanes; n++) begin
            prod_in_s[n*PW +: PW] = lane_product(a_i[n*Width +: Width],
                                                 b_i[n*Width +: Width]);
        end
    end

    generate
        if (Latency == 1) begin : g_direct
            assign post_src_s = prod_in_s;
        end else begin : g_prod_stage
            logic [Lanes*PW-1:0] prod_q;
            logic [Lanes*PW-1:0] prod_d;

            // Product register only captures valid incoming beats.
            always_comb begin
                if (cap_s[0]) begin
                    prod_d = prod_in_s;
                end else begin
                    prod_d = prod_q;
                end
            end

            // Raw product stage.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    prod_q <= {(Lanes*PW){1'b0}};
                end else begin
                    prod_q <= prod_d;
                end
            end

            assign post_src_s = prod_q;
        end
    endgenerate

    // Per-lane rounding, slicing and overflow handling.
    always_comb begin
        post_res_s = {RW{1'b0}};
        post_ovf_s = {Lanes{1'b0}};
        for (int n = 0; n < Lanes; n++) begin
            logic [Width:0] lane_v;
            lane_v                     = lane_round(post_src_s[n*PW +: PW]);
            post_res_s[n*Width +: Width] = lane_v[Width-1:0];
            post_ovf_s[n]              = lane_v[Width];
        end
    end

    logic [RW-1:0]    res_q [FirstIdx:Latency-1];
    logic [RW-1:0]    res_d [FirstIdx:Latency-1];
    logic [Lanes-1:0] ovf_q [FirstIdx:Latency-1];
    logic [Lanes-1:0] ovf_d [FirstIdx:Latency-1];

    // Result stages advance only on valid beats, so empty slots never feed forward.
    always_comb begin
        if (cap_s[FirstIdx]) begin
            res_d[FirstIdx] = post_res_s;
            ovf_d[FirstIdx] = post_ovf_s;
        end else begin
            res_d[FirstIdx] = res_q[FirstIdx];
            ovf_d[FirstIdx] = ovf_q[FirstIdx];
        end
        for (int k = FirstIdx + 1; k < Latency; k++) begin
            if (cap_s[k]) begin
                res_d[k] = res_q[k-1];
                ovf_d[k] = ovf_q[k-1];
            end else begin
                res_d[k] = res_q[k];
                ovf_d[k] = ovf_q[k];
            end
        end
    end

    // Result and overflow pipeline registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = FirstIdx; k < Latency; k++) begin
                res_q[k] <= {RW{1'b0}};
                ovf_q[k] <= {Lanes{1'b0}};
            end
        end else begin
            for (int k = FirstIdx; k < Latency; k++) begin
                res_q[k] <= res_d[k];
                ovf_q[k] <= ovf_d[k];
            end
        end
    end

    assign s_ready_o  = load_s[0];
    assign m_valid_o  = valid_q[Latency-1];
    assign m_o        = res_q[Latency-1];
    assign overflow_o = ovf_q[Latency-1];

endmodule

// File: tb/tb_fxp_multiplier.sv
// Directed testbench for fxp_multiplier (Width=16, Q10 in/out, Latency=2).
// Expectations for the saturating build follow FXP_MULTIPLIER_SAT_EN.
module tb_fxp_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] a, b, m;
    logic [0:0]  ovf;

    logic        s_valid4, s_ready4, m_valid4, m_ready4;
    logic [63:0] a4, b4, m4;
    logic [3:0]  ovf4;

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef FXP_MULTIPLIER_SAT_EN
    localparam logic [15:0] BigRes = 16'h7FFF;
    localparam logic [0:0]  BigOvf = 1'b1;
    localparam logic [3:0]  Ovf4   = 4'b0100;
`else
    localparam logic [15:0] BigRes = 16'hFFC0;
    localparam logic [0:0]  BigOvf = 1'b0;
    localparam logic [3:0]  Ovf4   = 4'b0000;
`endif

    fxp_multiplier u_dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .a_i(a), .b_i(b),
        .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_o(m), .overflow_o(ovf)
    );

    fxp_multiplier #(.Lanes(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid4), .s_ready_o(s_ready4),
        .a_i(a4), .b_i(b4),
        .m_valid_o(m_valid4), .m_ready_i(m_ready4),
        .m_o(m4), .overflow_o(ovf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; a = 16'h0000; b = 16'h0000;
        s_valid4 = 1'b0; m_ready4 = 1'b1; a4 = 64'h0; b4 = 64'h0;
        #1;
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b exp 0", m_valid); else pass_cnt++;
        chk_cnt++; if (m !== 16'h0000) $display("FAIL reset_m got %h exp 0000", m); else pass_cnt++;
        chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else pass_cnt++;
        chk_cnt++; if (m_valid4 !== 1'b0 || m4 !== 64'h0) $display("FAIL reset_lanes4 got %b/%h exp 0/0", m_valid4, m4); else pass_cnt++;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b exp 1", s_ready); else pass_cnt++;
        tick();
    endtask

    task automatic test_arith();
        logic [15:0] va [7];
        logic [15:0] vb [7];
        logic [15:0] vm [7];
        logic [0:0]  vo [7];
        va = '{16'h0600, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFC00, 16'h7FFF, 16'h8000};
        vb = '{16'h0800, 16'h0200, 16'h0200, 16'h0600, 16'h0A00, 16'h7FFF, 16'h0400};
        vm = '{16'h0C00, 16'h0001, 16'h0000, 16'hFFFF, 16'hF600, BigRes,   16'h8000};
        vo = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b0,     BigOvf,   1'b0};
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; a = va[i]; b = vb[i];
            tick();
            s_valid = 1'b0;
            #1;
            chk_cnt++; if (m_valid !== 1'b0) $display("FAIL arith%0d_early_valid got %b exp 0", i, m_valid); else pass_cnt++;
            tick();
            chk_cnt++; if (m_valid !== 1'b1) $display("FAIL arith%0d_valid got %b exp 1", i, m_valid); else pass_cnt++;
            chk_cnt++; if (m !== vm[i]) $display("FAIL arith%0d_m got %h exp %h", i, m, vm[i]); else pass_cnt++;
            chk_cnt++; if (ovf !== vo[i]) $display("FAIL arith%0d_ovf got %b exp %b", i, ovf, vo[i]); else pass_cnt++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] beats [5];
        logic [15:0] exps  [5];
        int sent = 0, got = 0, first_cyc = -1, last_cyc = -1;
        beats = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
        exps  = '{16'h0200, 16'h0400, 16'h0600, 16'h0800, 16'h0A00};
        m_ready = 1'b1; b = 16'h0800;
        for (int cyc = 0; cyc < 12 && got < 5; cyc++) begin
            s_valid = (sent < 5);
            a = (sent < 5) ? beats[sent] : 16'h0000;
            #1;
            if (s_valid) begin
                chk_cnt++; if (s_ready !== 1'b1) $display("FAIL b2b_s_ready cyc %0d got %b exp 1", cyc, s_ready); else pass_cnt++;
            end
            if (s_valid && s_ready) sent++;
            if (m_valid) begin
                chk_cnt++; if (m !== exps[got]) $display("FAIL b2b_m beat %0d got %h exp %h", got, m, exps[got]); else pass_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk_cnt++; if (got !== 5) $display("FAIL b2b_count got %0d exp 5", got); else pass_cnt++;
        chk_cnt++; if (last_cyc - first_cyc !== 4) $display("FAIL b2b_span got %0d exp 4", last_cyc - first_cyc); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] beats [4];
        int sent = 0, got = 0, first_cyc = -1, last_cyc = -1;
        beats = '{16'h0111, 16'h0222, 16'h0333, 16'h0444};
        m_ready = 1'b0; b = 16'h0400;
        for (int cyc = 0; cyc < 5; cyc++) begin
            s_valid = (sent < 4);
            a = beats[sent];
            #1;
            if (s_valid && s_ready) sent++;
            tick();
        end
        s_valid = 1'b1; a = beats[sent];
        #1;
        chk_cnt++; if (sent !== 2) $display("FAIL bp_accepted got %0d exp 2", sent); else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready got %b exp 0", s_ready); else pass_cnt++;
        chk_cnt++; if (m_valid !== 1'b1 || m !== 16'h0111) $display("FAIL bp_head got %b/%h exp 1/0111", m_valid, m); else pass_cnt++;
        tick();
        chk_cnt++; if (m_valid !== 1'b1 || m !== 16'h0111) $display("FAIL bp_hold got %b/%h exp 1/0111", m_valid, m); else pass_cnt++;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && got < 4; cyc++) begin
            s_valid = (sent < 4);
            a = (sent < 4) ? beats[sent] : 16'h0000;
            #1;
            if (cyc == 0) begin
                chk_cnt++; if (s_ready !== 1'b1 || m_valid !== 1'b1) $display("FAIL bp_full_passthru got %b/%b exp 1/1", s_ready, m_valid); else pass_cnt++;
            end
            if (s_valid && s_ready) sent++;
            if (m_valid) begin
                chk_cnt++; if (m !== beats[got]) $display("FAIL bp_order beat %0d got %h exp %h", got, m, beats[got]); else pass_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk_cnt++; if (got !== 4) $display("FAIL bp_count got %0d exp 4", got); else pass_cnt++;
        chk_cnt++; if (last_cyc - first_cyc !== 3) $display("FAIL bp_span got %0d exp 3", last_cyc - first_cyc); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        m_ready = 1'b1; s_valid = 1'b1; a = 16'h0600; b = 16'h0800;
        tick();
        a = 16'h0001; b = 16'h0200;
        tick();
        s_valid = 1'b0;
        chk_cnt++; if (m_valid !== 1'b1 || m !== 16'h0C00) $display("FAIL mid_inflight got %b/%h exp 1/0C00", m_valid, m); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", m_valid); else pass_cnt++;
        chk_cnt++; if (m !== 16'h0000) $display("FAIL mid_rst_m got %h exp 0000", m); else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        chk_cnt++; if (s_ready !== 1'b1) $display("FAIL mid_s_ready got %b exp 1", s_ready); else pass_cnt++;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            if (m_valid !== 1'b0) stale++;
        end
        chk_cnt++; if (stale !== 0) $display("FAIL mid_stale got %0d exp 0", stale); else pass_cnt++;
    endtask

    task automatic test_lanes();
        logic [63:0] exp_m;
        exp_m = {16'h8000, BigRes, 16'h0001, 16'h0C00};
        m_ready4 = 1'b1; s_valid4 = 1'b1;
        a4 = {16'h8000, 16'h7FFF, 16'h0001, 16'h0600};
        b4 = {16'h0400, 16'h7FFF, 16'h0200, 16'h0800};
        #1;
        chk_cnt++; if (s_ready4 !== 1'b1) $display("FAIL lanes_s_ready got %b exp 1", s_ready4); else pass_cnt++;
        tick();
        s_valid4 = 1'b0;
        tick();
        chk_cnt++; if (m_valid4 !== 1'b1) $display("FAIL lanes_valid got %b exp 1", m_valid4); else pass_cnt++;
        chk_cnt++; if (m4 !== exp_m) $display("FAIL lanes_m got %h exp %h", m4, exp_m); else pass_cnt++;
        chk_cnt++; if (ovf4 !== Ovf4) $display("FAIL lanes_ovf got %b exp %b", ovf4, Ovf4); else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_lanes();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
